// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: bus widths, the ROM's writable word,
// the default copy destination, and the copy sequencer state type.
package boot_pkg;

  localparam int BOOT_DW     = 16;
  localparam int BOOT_ROM_AW = 4;
  localparam int BOOT_MEM_AW = 8;

  // Only this ROM word accepts writes; it is the patch target.
  localparam logic [BOOT_ROM_AW-1:0] BOOT_PATCH_ADDR = 4'h7;

  // Default first main-memory destination address.
  localparam logic [BOOT_MEM_AW-1:0] BOOT_LOAD_BASE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PATCH_SETUP,
    ST_PATCH_WR,
    ST_RD_ADDR,
    ST_RD_CAP,
    ST_MEM_WR,
    ST_DONE
  } boot_state_e;

endpackage

// File: rtl/boot_loader.sv
// boot_loader: copies LOAD_LEN words of the boot ROM into main memory before
// the CPU leaves reset, optionally patching the ROM's writable word first.
//
// Ports:
//   romclk, rst            clock, asynchronous active-high reset
//   start                  one-cycle pulse; accepted only when idle or done
//   patch_en, patch_data   sampled with start; request a patch write first
//   rom_cs/we/addr/din     ROM port driven by this initiator
//   rom_dout               ROM read data (valid two cycles after address)
//   mem_req/addr/wdata     main-memory write request, held until mem_ack
//   mem_ack                memory accepted the write this cycle
//   busy, done             copy in progress / copy complete (sticky)
//   words_done             number of words written to memory
module boot_loader
  import boot_pkg::*;
#(
  parameter int                DW         = BOOT_DW,
  parameter int                ROM_AW     = BOOT_ROM_AW,
  parameter int                MEM_AW     = BOOT_MEM_AW,
  parameter int                LOAD_LEN   = 16,
  parameter logic [MEM_AW-1:0] LOAD_BASE  = BOOT_LOAD_BASE,
  parameter logic [ROM_AW-1:0] PATCH_ADDR = BOOT_PATCH_ADDR,
  parameter bit                AUTO_START = 1'b1
) (
  input  logic              romclk,
  input  logic              rst,
  input  logic              start,
  input  logic              patch_en,
  input  logic [DW-1:0]     patch_data,
  output logic              rom_cs,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [DW-1:0]     rom_din,
  input  logic [DW-1:0]     rom_dout,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic [ROM_AW:0]   words_done
);

  localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(LOAD_LEN - 1);

  boot_state_e       state;
  logic [ROM_AW-1:0] index;
  // Set by reset and cleared on the first clock edge afterwards, so that edge
  // can stand in for a start pulse when AUTO_START is enabled.
  logic              auto_pend;
  logic              go;
  logic              go_patch;

  always_comb begin
    go       = start | (auto_pend & AUTO_START);
    go_patch = start & patch_en;
  end

  // All outputs are registered and loaded on the transition into the state
  // that owns them, so each output already matches its state in that cycle.
  always_ff @(posedge romclk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      auto_pend  <= 1'b1;
      index      <= '0;
      rom_cs     <= 1'b0;
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_din    <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= LOAD_BASE;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      words_done <= '0;
    end else begin
      auto_pend <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (go) begin
            words_done <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            index      <= '0;
            rom_cs     <= 1'b1;
            if (go_patch) begin
              state    <= ST_PATCH_SETUP;
              rom_we   <= 1'b1;
              rom_addr <= PATCH_ADDR;
              rom_din  <= patch_data;
            end else begin
              state    <= ST_RD_ADDR;
              rom_we   <= 1'b0;
              rom_addr <= '0;
              rom_din  <= '0;
            end
          end
        end

        // Write strobe held for two cycles so the ROM's latched address and
        // data are stable under its write edge.
        ST_PATCH_SETUP: begin
          state <= ST_PATCH_WR;
        end

        ST_PATCH_WR: begin
          state    <= ST_RD_ADDR;
          rom_we   <= 1'b0;
          rom_din  <= '0;
          rom_addr <= index;
        end

        ST_RD_ADDR: begin
          state <= ST_RD_CAP;
        end

        // ROM data becomes valid two cycles after the address; capture it at
        // the end of the second read cycle and hand the bus to memory.
        ST_RD_CAP: begin
          state     <= ST_MEM_WR;
          mem_wdata <= rom_dout;
          rom_cs    <= 1'b0;
          mem_req   <= 1'b1;
          mem_addr  <= LOAD_BASE + MEM_AW'(index);
        end

        ST_MEM_WR: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            words_done <= words_done + 1'b1;
            if (index == LAST_IDX) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= ST_RD_ADDR;
              index    <= index + 1'b1;
              rom_cs   <= 1'b1;
              rom_addr <= index + 1'b1;
            end
          end
        end

        default: begin
          state   <= ST_IDLE;
          rom_cs  <= 1'b0;
          rom_we  <= 1'b0;
          rom_din <= '0;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Bus initiator that reads the 16x16 boot ROM and copies its words into main memory before the CPU leaves reset.
- Sits between the boot ROM's cs/we/addr/din/dout port and the main-memory write port.
- Optional single patch write to the ROM's writable word before the copy.
- Asserts done and releases both buses when the copy finishes.

Parameters:
- DW, 16, data width of ROM and memory words
- ROM_AW, 4, ROM address width
- MEM_AW, 8, main-memory address width
- LOAD_LEN, 16, words copied (1..2^ROM_AW)
- LOAD_BASE, 8'h00, first main-memory destination address
- PATCH_ADDR, 4'h7, ROM address of the writable word
- AUTO_START, 1, 1 = begin the copy on the first romclk edge after rst deasserts

Ports:
- romclk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle pulse that begins a copy (ignored unless IDLE or DONE)
- patch_en  in  1  sampled with start; 1 = write patch_data to PATCH_ADDR before reading
- patch_data  in  DW  patch word
- rom_cs  out  1  ROM chip select
- rom_we  out  1  ROM write enable
- rom_addr  out  ROM_AW  ROM address
- rom_din  out  DW  ROM write data
- rom_dout  in  DW  ROM read data
- mem_req  out  1  memory write request
- mem_addr  out  MEM_AW  memory address
- mem_wdata  out  DW  memory write data
- mem_ack  in  1  memory accepted the write (same-cycle handshake)
- busy  out  1  copy in progress
- done  out  1  copy complete (sticky until the next start or rst)
- words_done  out  ROM_AW+1  count of words written to memory

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock romclk. All flops are posedge romclk with async clear on rst.
- Reset values: all outputs 0; rom_addr=0; mem_addr=LOAD_BASE; FSM in IDLE.
- FSM states: IDLE, PATCH_SETUP, PATCH_WR, RD_ADDR, RD_CAP, MEM_WR, DONE.
- IDLE:
  - On start=1: clear words_done and done; go to PATCH_SETUP if patch_en=1, else RD_ADDR.
  - If AUTO_START=1, the first edge after rst release acts as start with patch_en=0.
- PATCH_SETUP: rom_cs=1, rom_we=1, rom_addr=PATCH_ADDR, rom_din=patch_data. Next state PATCH_WR.
- PATCH_WR: same outputs held for a second cycle so the ROM's latched addr/data are stable under the write clock edge. Next state RD_ADDR.
- RD_ADDR: rom_cs=1, rom_we=0, rom_addr=word index.
- RD_CAP: outputs held as in RD_ADDR. Capture rom_dout into mem_wdata at the end of the cycle (2-cycle read latency).
- MEM_WR:
  - mem_req=1, mem_addr=LOAD_BASE+index, rom_cs=0.
  - Hold until mem_ack=1; mem_req/mem_addr/mem_wdata stay stable while waiting.
  - On ack: words_done+1. If index==LOAD_LEN-1 go to DONE, else index+1 and go to RD_ADDR.
- DONE: done=1, busy=0, rom_cs=0, mem_req=0. start restarts the copy from IDLE rules.
- busy=1 in every state except IDLE and DONE.
- rom_din=0 whenever rom_we=0.
- Boundaries:
  - No address wrap; the index stops at LOAD_LEN-1.
  - mem_addr wraps modulo 2^MEM_AW when LOAD_BASE+LOAD_LEN overflows.
  - start while busy is ignored.
  - rst mid-operation aborts immediately; all outputs return to reset values and no partial handshake completes.
  - mem_ack outside MEM_WR is ignored.
  - rom_cs and mem_req are never both 1 in the same cycle.
- Throughput: 3 cycles per word with mem_ack tied high. Full 16-word copy = 48 cycles from start to done.

Decomposition:
- Shared package boot_pkg holds:
  - FSM state enum
  - DW, ROM_AW, MEM_AW
  - PATCH_ADDR
  - default LOAD_BASE
- Single module. No sub-module is warranted; the index counter and mem_addr adder stay inline.

Test Plan:
- ROM model preloaded F200,4000,F800,1007,F400,3007,4000,0000..., mem_ack=1, AUTO_START=1 -> memory[0..15] matches the ROM, done rises 48 cycles after rst release, words_done=16.
- start with patch_en=1, patch_data=16'hABCD -> one ROM write cycle pair to addr 7, then memory[7]=ABCD; all other words unchanged.
- mem_ack held low 5 cycles on word 3 -> mem_req, mem_addr=3 and mem_wdata=1007 stay stable all 5 cycles; copy then resumes correctly.
- rst asserted during MEM_WR of word 9 -> all outputs 0 on the same cycle; the next start recopies from word 0.
- LOAD_BASE=8'hF8, LOAD_LEN=16 -> mem_addr runs F8..FF then 00..07; pulse start while busy -> no effect.
- Bench assertion: rom_cs & mem_req never both 1 in any cycle of all scenarios above.
